// File: rtl/snn_pkg.sv
// Shared definitions for the SNN stream driver: buffer sizes, response width,
// FSM state encoding, buffer-select encodings and the write address check.
package snn_pkg;

  localparam int IMG_DIM   = 6;
  localparam int KER_DIM   = 3;
  localparam int IMG_BYTES = 2 * IMG_DIM * IMG_DIM;
  localparam int KER_BYTES = KER_DIM * KER_DIM;
  localparam int W_BYTES   = 4;
  localparam int OUT_W     = 10;
  localparam int IDX_W     = 7;

  localparam logic [IDX_W-1:0] IMG_LEN  = IDX_W'(IMG_BYTES);
  localparam logic [IDX_W-1:0] KER_LEN  = IDX_W'(KER_BYTES);
  localparam logic [IDX_W-1:0] W_LEN    = IDX_W'(W_BYTES);
  localparam logic [IDX_W-1:0] IMG_LAST = IDX_W'(IMG_BYTES - 1);

  localparam logic [1:0] SEL_IMG  = 2'd0;
  localparam logic [1:0] SEL_KER  = 2'd1;
  localparam logic [1:0] SEL_W    = 2'd2;
  localparam logic [1:0] SEL_RSVD = 2'd3;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_e;

  // True when the address lands inside the selected buffer.
  function automatic logic addr_ok(input logic [1:0] sel, input logic [IDX_W-1:0] addr);
    logic ok;
    case (sel)
      SEL_IMG: ok = (addr < IMG_LEN);
      SEL_KER: ok = (addr < KER_LEN);
      SEL_W:   ok = (addr < W_LEN);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/snn_stream_buf.sv
// Image / kernel / weight byte storage for the stream driver.
// Ports:
//   clk, rst_n          clock, async active-low reset (clears all bytes)
//   wr_en_i             write strobe (already qualified by the caller)
//   wr_sel_i/addr/data  buffer select, byte index, data
//   rd_idx_i            stream index read by all three buffers at once
//   img_o/ker_o/w_o     byte at rd_idx_i, 0 when the index is out of range
module snn_stream_buf
  import snn_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [1:0]       wr_sel_i,
  input  logic [IDX_W-1:0] wr_addr_i,
  input  logic [7:0]       wr_data_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [7:0]       img_o,
  output logic [7:0]       ker_o,
  output logic [7:0]       w_o
);

  logic [7:0] img_q [IMG_BYTES];
  logic [7:0] ker_q [KER_BYTES];
  logic [7:0] w_q   [W_BYTES];

  logic wr_ok;
  assign wr_ok = wr_en_i && addr_ok(wr_sel_i, wr_addr_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IMG_BYTES; i++) img_q[i] <= '0;
      for (int i = 0; i < KER_BYTES; i++) ker_q[i] <= '0;
      for (int i = 0; i < W_BYTES; i++)   w_q[i]   <= '0;
    end else if (wr_ok) begin
      case (wr_sel_i)
        SEL_IMG: img_q[wr_addr_i]      <= wr_data_i;
        SEL_KER: ker_q[wr_addr_i[3:0]] <= wr_data_i;
        SEL_W:   w_q[wr_addr_i[1:0]]   <= wr_data_i;
        default: ;
      endcase
    end
  end

  // A write landing on the byte being read is forwarded, so a write issued
  // together with start is already visible in the first streamed byte.
  always_comb begin
    img_o = '0;
    ker_o = '0;
    w_o   = '0;
    if (rd_idx_i < IMG_LEN)
      img_o = (wr_ok && wr_sel_i == SEL_IMG && wr_addr_i == rd_idx_i) ? wr_data_i : img_q[rd_idx_i];
    if (rd_idx_i < KER_LEN)
      ker_o = (wr_ok && wr_sel_i == SEL_KER && wr_addr_i == rd_idx_i) ? wr_data_i : ker_q[rd_idx_i[3:0]];
    if (rd_idx_i < W_LEN)
      w_o = (wr_ok && wr_sel_i == SEL_W && wr_addr_i == rd_idx_i) ? wr_data_i : w_q[rd_idx_i[1:0]];
  end

endmodule

// File: rtl/snn_stream_driver.sv
// Host-side transmitter for the SNN input protocol. Streams two 6x6 images,
// a 3x3 kernel and 2x2 weights as one 72-cycle in_valid burst, then waits for
// the single-cycle response and captures its data and latency.
//
// state | meaning
// IDLE  | buffers writable, waiting for start
// SEND  | streaming byte k = 0..71
// WAIT  | burst done, counting cycles until response or timeout
// DONE  | one-cycle done pulse, then back to IDLE
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   wr_*_i                buffer write port (applied in IDLE only)
//   start_i               launch a transfer (IDLE only)
//   in_valid_o, img_o, ker_o, weight_o   registered stream to the SNN
//   snn_out_valid_i, snn_out_data_i      response from the SNN
//   busy_o, done_o        status
//   result_o, lat_o       captured response data and latency
//   timeout_o, err_o      sticky per-transfer flags
module snn_stream_driver
  import snn_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [1:0]       wr_sel_i,
  input  logic [IDX_W-1:0] wr_addr_i,
  input  logic [7:0]       wr_data_i,
  input  logic             start_i,
  output logic             in_valid_o,
  output logic [7:0]       img_o,
  output logic [7:0]       ker_o,
  output logic [7:0]       weight_o,
  input  logic             snn_out_valid_i,
  input  logic [OUT_W-1:0] snn_out_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [OUT_W-1:0] result_o,
  output logic [7:0]       lat_o,
  output logic             timeout_o,
  output logic             err_o
);

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  state_e           state_q;
  logic [IDX_W-1:0] k_q;
  logic             in_valid_q, done_q, timeout_q, err_q, err_pend_q;
  logic [7:0]       img_q, ker_q, w_q, lat_q;
  logic [OUT_W-1:0] result_q;

  logic             idle, wr_ok, wr_bad;
  logic [IDX_W-1:0] rd_idx;
  logic [7:0]       rd_img, rd_ker, rd_w;

  assign idle   = (state_q == IDLE);
  assign wr_ok  = wr_en_i && idle && addr_ok(wr_sel_i, wr_addr_i);
  assign wr_bad = wr_en_i && !wr_ok;
  // Outputs are registered, so the buffer is read one index ahead.
  assign rd_idx = idle ? '0 : k_q + 7'd1;

  snn_stream_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_ok),
    .wr_sel_i  (wr_sel_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .rd_idx_i  (rd_idx),
    .img_o     (rd_img),
    .ker_o     (rd_ker),
    .w_o       (rd_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      k_q        <= '0;
      in_valid_q <= 1'b0;
      img_q      <= '0;
      ker_q      <= '0;
      w_q        <= '0;
      done_q     <= 1'b0;
      result_q   <= '0;
      lat_q      <= '0;
      timeout_q  <= 1'b0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q    <= SEND;
            k_q        <= '0;
            in_valid_q <= 1'b1;
            img_q      <= rd_img;
            ker_q      <= rd_ker;
            w_q        <= rd_w;
            result_q   <= '0;
            lat_q      <= '0;
            timeout_q  <= 1'b0;
            // A bad write seen while idle is charged to this transfer.
            err_q      <= err_pend_q | wr_bad;
            err_pend_q <= 1'b0;
          end else if (wr_bad) begin
            err_pend_q <= 1'b1;
          end
        end
        SEND: begin
          if (snn_out_valid_i || wr_bad) err_q <= 1'b1;
          if (k_q == IMG_LAST) begin
            state_q    <= WAIT;
            in_valid_q <= 1'b0;
            img_q      <= '0;
            ker_q      <= '0;
            w_q        <= '0;
            lat_q      <= 8'd1;
          end else begin
            k_q   <= k_q + 7'd1;
            img_q <= rd_img;
            ker_q <= rd_ker;
            w_q   <= rd_w;
          end
        end
        WAIT: begin
          if (wr_bad) err_q <= 1'b1;
          if (snn_out_valid_i) begin
            result_q <= snn_out_data_i;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else if (lat_q >= TO_CNT) begin
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else if (lat_q != 8'hFF) begin
            lat_q <= lat_q + 8'd1;
          end
        end
        DONE: begin
          if (snn_out_valid_i || wr_bad) err_q <= 1'b1;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_valid_o = in_valid_q;
  assign img_o      = img_q;
  assign ker_o      = ker_q;
  assign weight_o   = w_q;
  assign busy_o     = !idle;
  assign done_o     = done_q;
  assign result_o   = result_q;
  assign lat_o      = lat_q;
  assign timeout_o  = timeout_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_snn_stream_driver.sv
module tb_snn_stream_driver;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en_i = 1'b0;
  logic [1:0] wr_sel_i = '0;
  logic [6:0] wr_addr_i = '0;
  logic [7:0] wr_data_i = '0;
  logic       start_i = 1'b0;
  logic       in_valid_o;
  logic [7:0] img_o, ker_o, weight_o;
  logic       snn_out_valid_i = 1'b0;
  logic [9:0] snn_out_data_i = '0;
  logic       busy_o, done_o;
  logic [9:0] result_o;
  logic [7:0] lat_o;
  logic       timeout_o, err_o;

  always #5 clk = ~clk;

  snn_stream_driver #(.TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_en_i         (wr_en_i),
    .wr_sel_i        (wr_sel_i),
    .wr_addr_i       (wr_addr_i),
    .wr_data_i       (wr_data_i),
    .start_i         (start_i),
    .in_valid_o      (in_valid_o),
    .img_o           (img_o),
    .ker_o           (ker_o),
    .weight_o        (weight_o),
    .snn_out_valid_i (snn_out_valid_i),
    .snn_out_data_i  (snn_out_data_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .result_o        (result_o),
    .lat_o           (lat_o),
    .timeout_o       (timeout_o),
    .err_o           (err_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference buffers: what the host believes it has written.
  logic [7:0] img_m [72];
  logic [7:0] ker_m [9];
  logic [7:0] w_m   [4];

  // Observations of the last transfer.
  logic [7:0] cap_img [72];
  logic [7:0] cap_ker [72];
  logic [7:0] cap_w   [72];
  int         n_valid, n_rise, n_done, wait_cnt;
  logic [9:0] obs_result, obs_res_send;
  logic [7:0] obs_lat;
  logic       obs_to, obs_err, obs_to_first;

  function automatic int first_bad();
    logic [7:0] ek, ew;
    for (int k = 0; k < 72; k++) begin
      ek = 8'h00;
      ew = 8'h00;
      if (k < 9) ek = ker_m[k];
      if (k < 4) ew = w_m[k];
      if (cap_img[k] !== img_m[k] || cap_ker[k] !== ek || cap_w[k] !== ew) return k;
    end
    return -1;
  endfunction

  task automatic bus_write(input logic [1:0] sel, input logic [6:0] addr, input logic [7:0] data);
    @(negedge clk);
    wr_en_i = 1'b1; wr_sel_i = sel; wr_addr_i = addr; wr_data_i = data;
    @(negedge clk);
    wr_en_i = 1'b0;
    if (sel == 2'd0 && addr < 72) img_m[addr] = data;
    if (sel == 2'd1 && addr < 9)  ker_m[addr] = data;
    if (sel == 2'd2 && addr < 4)  w_m[addr]   = data;
  endtask

  // Runs one transfer and records what the DUT did. resp_at = WAIT cycle on
  // which the response is driven (0 = never); spur_at / busy_at = SEND cycle
  // for a spurious response or for a start+write while busy (-1 = none).
  task automatic do_transfer(input int resp_at, input logic [9:0] resp_data,
                             input int spur_at, input int busy_at,
                             input bit wr_at_start, input logic [6:0] ws_addr,
                             input logic [7:0] ws_data);
    bit prev_v;
    bit finished;
    int idle_after;
    n_valid = 0; n_rise = 0; n_done = 0; wait_cnt = 0;
    prev_v = 1'b0; finished = 1'b0; idle_after = 0;
    obs_result = 'x; obs_lat = 'x; obs_to = 1'bx; obs_err = 1'bx; obs_res_send = 'x;
    for (int k = 0; k < 72; k++) begin cap_img[k] = 'x; cap_ker[k] = 'x; cap_w[k] = 'x; end
    @(negedge clk);
    start_i = 1'b1;
    if (wr_at_start) begin
      wr_en_i = 1'b1; wr_sel_i = 2'd0; wr_addr_i = ws_addr; wr_data_i = ws_data;
      img_m[ws_addr] = ws_data;
    end
    @(negedge clk);
    obs_to_first = timeout_o;
    for (int c = 0; c < 400 && !finished; c++) begin
      start_i = 1'b0; wr_en_i = 1'b0; snn_out_valid_i = 1'b0;
      if (in_valid_o) begin
        if (!prev_v) n_rise++;
        if (n_valid < 72) begin
          cap_img[n_valid] = img_o; cap_ker[n_valid] = ker_o; cap_w[n_valid] = weight_o;
        end
        if (n_valid == 71) obs_res_send = result_o;
        if (n_valid == spur_at) begin snn_out_valid_i = 1'b1; snn_out_data_i = 10'd7; end
        if (n_valid == busy_at) begin
          start_i = 1'b1; wr_en_i = 1'b1; wr_sel_i = 2'd0; wr_addr_i = 7'd3; wr_data_i = 8'hFF;
        end
        n_valid++;
      end else if (busy_o && !done_o) begin
        wait_cnt++;
        if (wait_cnt == resp_at) begin snn_out_valid_i = 1'b1; snn_out_data_i = resp_data; end
      end
      if (done_o) begin
        n_done++;
        obs_result = result_o; obs_lat = lat_o; obs_to = timeout_o; obs_err = err_o;
      end
      if (n_done > 0 && !busy_o) begin
        idle_after++;
        if (idle_after >= 4) finished = 1'b1;
      end
      prev_v = in_valid_o;
      @(negedge clk);
    end
    start_i = 1'b0; wr_en_i = 1'b0; snn_out_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({in_valid_o, img_o, ker_o, weight_o, busy_o, done_o, result_o, lat_o, timeout_o, err_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got iv=%b img=%h ker=%h w=%h busy=%b done=%b res=%h lat=%h to=%b err=%b, want all 0",
               in_valid_o, img_o, ker_o, weight_o, busy_o, done_o, result_o, lat_o, timeout_o, err_o);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 72; i++) img_m[i] = 8'h00;
    for (int i = 0; i < 9; i++)  ker_m[i] = 8'h00;
    for (int i = 0; i < 4; i++)  w_m[i]   = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stream();
    int fb;
    for (int i = 0; i < 72; i++) bus_write(2'd0, 7'(i), 8'(i));
    for (int i = 0; i < 9; i++)  bus_write(2'd1, 7'(i), 8'(i + 1));
    for (int i = 0; i < 4; i++)  bus_write(2'd2, 7'(i), 8'(i + 10));
    do_transfer(5, 10'h2A, -1, -1, 1'b0, 7'd0, 8'd0);
    fb = first_bad();
    n_cmp++;
    if (fb != -1) begin
      n_err++;
      $display("FAIL stream_order: idx %0d got img=%h ker=%h w=%h", fb, cap_img[fb], cap_ker[fb], cap_w[fb]);
    end
    n_cmp++;
    if (n_valid != 72 || n_rise != 1) begin
      n_err++;
      $display("FAIL stream_len: got %0d valid cycles in %0d runs, want 72 in 1", n_valid, n_rise);
    end
    n_cmp++;
    if (obs_result !== 10'd42) begin n_err++; $display("FAIL resp_result: got %0d want 42", obs_result); end
    n_cmp++;
    if (obs_lat !== 8'd5) begin n_err++; $display("FAIL resp_lat: got %0d want 5", obs_lat); end
    n_cmp++;
    if (n_done != 1) begin n_err++; $display("FAIL resp_done: got %0d pulses want 1", n_done); end
    n_cmp++;
    if (obs_to !== 1'b0 || obs_err !== 1'b0) begin
      n_err++; $display("FAIL resp_flags: got to=%b err=%b want 0 0", obs_to, obs_err);
    end
    n_cmp++;
    if (result_o !== 10'd42 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL resp_hold: got res=%0d busy=%b want 42 0", result_o, busy_o);
    end
  endtask

  task automatic test_random();
    int fb, rat;
    logic [9:0] rd;
    logic [6:0] wa;
    for (int it = 0; it < 4; it++) begin
      for (int j = 0; j < 12; j++) begin
        case ($urandom_range(0, 2))
          0: bus_write(2'd0, 7'($urandom_range(0, 71)), 8'($urandom));
          1: bus_write(2'd1, 7'($urandom_range(0, 8)), 8'($urandom));
          default: bus_write(2'd2, 7'($urandom_range(0, 3)), 8'($urandom));
        endcase
      end
      rat = $urandom_range(1, TO);
      rd  = 10'($urandom);
      wa  = (it == 0) ? 7'd0 : 7'($urandom_range(0, 71));
      do_transfer(rat, rd, -1, -1, 1'b1, wa, 8'($urandom));
      fb = first_bad();
      n_cmp++;
      if (fb != -1) begin
        n_err++;
        $display("FAIL rand_stream it%0d: idx %0d got img=%h ker=%h w=%h", it, fb, cap_img[fb], cap_ker[fb], cap_w[fb]);
      end
      n_cmp++;
      if (obs_result !== rd || obs_lat !== 8'(rat) || n_done != 1 || obs_err !== 1'b0) begin
        n_err++;
        $display("FAIL rand_resp it%0d: got res=%h lat=%0d done=%0d err=%b want res=%h lat=%0d done=1 err=0",
                 it, obs_result, obs_lat, n_done, obs_err, rd, rat);
      end
    end
  endtask

  task automatic test_timeout();
    do_transfer(0, 10'd0, -1, -1, 1'b0, 7'd0, 8'd0);
    n_cmp++;
    if (n_done != 1 || wait_cnt != TO) begin
      n_err++; $display("FAIL to_cycles: got done=%0d after %0d WAIT cycles want 1 after %0d", n_done, wait_cnt, TO);
    end
    n_cmp++;
    if (obs_to !== 1'b1 || obs_result !== 10'd0) begin
      n_err++; $display("FAIL to_flags: got to=%b res=%h want 1 0", obs_to, obs_result);
    end
    do_transfer(3, 10'h3FF, -1, -1, 1'b0, 7'd0, 8'd0);
    n_cmp++;
    if (obs_to_first !== 1'b0 || obs_to !== 1'b0 || obs_result !== 10'h3FF) begin
      n_err++; $display("FAIL to_clear: got to@start=%b to=%b res=%h want 0 0 3ff", obs_to_first, obs_to, obs_result);
    end
  endtask

  task automatic test_busy();
    int fb;
    do_transfer(2, 10'h11, -1, 10, 1'b0, 7'd0, 8'd0);
    n_cmp++;
    if (n_valid != 72 || n_rise != 1 || n_done != 1) begin
      n_err++; $display("FAIL busy_burst: got %0d valid in %0d runs, %0d done, want 72/1/1", n_valid, n_rise, n_done);
    end
    n_cmp++;
    if (obs_err !== 1'b1) begin n_err++; $display("FAIL busy_err: got %b want 1", obs_err); end
    do_transfer(4, 10'h55, -1, -1, 1'b0, 7'd0, 8'd0);
    fb = first_bad();
    n_cmp++;
    if (fb != -1 || cap_img[3] === 8'hFF) begin
      n_err++; $display("FAIL busy_write_dropped: idx %0d img3=%h want img3=%h", fb, cap_img[3], img_m[3]);
    end
    n_cmp++;
    if (obs_err !== 1'b0) begin n_err++; $display("FAIL busy_err_clear: got %b want 0", obs_err); end
  endtask

  task automatic test_spurious();
    do_transfer(6, 10'h100, 40, -1, 1'b0, 7'd0, 8'd0);
    n_cmp++;
    if (obs_res_send !== 10'd0) begin n_err++; $display("FAIL spur_not_captured: got %0d want 0", obs_res_send); end
    n_cmp++;
    if (obs_err !== 1'b1 || obs_result !== 10'd256) begin
      n_err++; $display("FAIL spur_resp: got err=%b res=%0d want 1 256", obs_err, obs_result);
    end
  endtask

  task automatic test_bad_write();
    int fb;
    bus_write(2'd0, 7'd72, 8'hAA);
    bus_write(2'd3, 7'd0, 8'hBB);
    bus_write(2'd1, 7'd9, 8'hCC);
    do_transfer(1, 10'h2, -1, -1, 1'b0, 7'd0, 8'd0);
    fb = first_bad();
    n_cmp++;
    if (obs_err !== 1'b1 || fb != -1) begin
      n_err++; $display("FAIL badwr_err: got err=%b bad idx %0d want err=1 idx -1", obs_err, fb);
    end
    do_transfer(1, 10'h3, -1, -1, 1'b0, 7'd0, 8'd0);
    n_cmp++;
    if (obs_err !== 1'b0) begin n_err++; $display("FAIL badwr_clear: got %b want 0", obs_err); end
  endtask

  task automatic test_reset_mid();
    int fb;
    logic iv_before;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (30) @(negedge clk);
    iv_before = in_valid_o;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (iv_before !== 1'b1 || in_valid_o !== 1'b0) begin
      n_err++; $display("FAIL rstmid_drop: got iv before=%b after=%b want 1 0", iv_before, in_valid_o);
    end
    n_cmp++;
    if ({img_o, ker_o, weight_o, busy_o, done_o, result_o, lat_o, timeout_o, err_o} !== '0) begin
      n_err++; $display("FAIL rstmid_outputs: got img=%h ker=%h w=%h busy=%b done=%b res=%h lat=%h to=%b err=%b want all 0",
                        img_o, ker_o, weight_o, busy_o, done_o, result_o, lat_o, timeout_o, err_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 72; i++) img_m[i] = 8'h00;
    for (int i = 0; i < 9; i++)  ker_m[i] = 8'h00;
    for (int i = 0; i < 4; i++)  w_m[i]   = 8'h00;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (busy_o !== 1'b0 || in_valid_o !== 1'b0) begin
      n_err++; $display("FAIL rstmid_idle: got busy=%b iv=%b want 0 0", busy_o, in_valid_o);
    end
    do_transfer(1, 10'h3, -1, -1, 1'b0, 7'd0, 8'd0);
    fb = first_bad();
    n_cmp++;
    if (fb != -1 || obs_result !== 10'd3) begin
      n_err++; $display("FAIL rstmid_after: bad idx %0d res=%0d want -1 3", fb, obs_result);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_random();
    test_timeout();
    test_busy();
    test_spurious();
    test_bad_write();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
